// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for an instruction fetch front end. After reset
//   it spends one BOOT cycle, then free-runs by STEP per cycle. Branch/jump
//   redirects are always accepted. A redirect that arrives while fetch is
//   stalled is parked in a one-entry buffer and applied when the stall clears.
//
// Parameters
//   ADDR_W    program-counter width in bits
//   STEP      sequential increment (1 .. 2^ADDR_W-1)
//   RESET_PC  PC value loaded by reset
//
// Ports
//   i_clk              sole clock, rising edge
//   i_rst              asynchronous active-high reset
//   i_stall            hold PC this cycle
//   i_redirect_valid   branch/jump request this cycle (never back-pressured)
//   i_redirect_target  target address, qualified by i_redirect_valid
//   o_pc               registered current fetch address
//   o_pc_plus          combinational (pc + STEP) mod 2^ADDR_W
//   o_pc_valid         registered, high when o_pc is a valid fetch address
//   o_pending          registered, high while a redirect is buffered
//   o_redirect_ack     registered one-cycle pulse after each redirect request
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int STEP     = 4,
  parameter int RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_target,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus,
  output logic              o_pc_valid,
  output logic              o_pending,
  output logic              o_redirect_ack
);

  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    HOLD      = 2'd2,
    HOLD_PEND = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_buf;
  logic              r_pc_valid;
  logic              r_pending;
  logic              r_ack;
  logic [ADDR_W-1:0] w_pc_plus;

  // Truncating add gives the modulo-2^ADDR_W wrap for free.
  assign w_pc_plus = r_pc + STEP_V;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC_V;
      r_buf      <= '0;
      r_pc_valid <= 1'b0;
      r_pending  <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      // Every request is acknowledged, even ones later overwritten in the
      // buffer or superseded by a newer request.
      r_ack <= i_redirect_valid;

      case (r_state)
        BOOT: begin
          // Stall is ignored here; only a redirect can move the PC.
          if (i_redirect_valid) begin
            r_pc <= i_redirect_target;
          end
          r_pc_valid <= 1'b1;
          r_state    <= RUN;
        end

        RUN, HOLD: begin
          if (i_stall) begin
            if (i_redirect_valid) begin
              r_buf     <= i_redirect_target;
              r_pending <= 1'b1;
              r_state   <= HOLD_PEND;
            end else begin
              r_state <= HOLD;
            end
          end else begin
            r_pc    <= i_redirect_valid ? i_redirect_target : w_pc_plus;
            r_state <= RUN;
          end
        end

        HOLD_PEND: begin
          if (i_stall) begin
            // Newest request overwrites the parked one.
            if (i_redirect_valid) begin
              r_buf <= i_redirect_target;
            end
          end else begin
            // A request arriving on the release cycle beats the parked one.
            r_pc      <= i_redirect_valid ? i_redirect_target : r_buf;
            r_buf     <= '0;
            r_pending <= 1'b0;
            r_state   <= RUN;
          end
        end

        default: begin
          r_state    <= BOOT;
          r_pc_valid <= 1'b0;
          r_pending  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc           = r_pc;
  assign o_pc_plus      = w_pc_plus;
  assign o_pc_valid     = r_pc_valid;
  assign o_pending      = r_pending;
  assign o_redirect_ack = r_ack;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer (ADDR_W=8, STEP=4, RESET_PC=0).
//   Directed scenarios plus randomized stall/redirect/reset traffic, all
//   compared against a behavioural model: a PC value, a "still booting" flag
//   and a queue holding at most one parked redirect target.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int ADDR_W = 8;
  localparam int STEP   = 4;
  localparam int MOD    = 256;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              pc_valid;
  logic              pending;
  logic              redirect_ack;

  pc_sequencer #(
    .ADDR_W   (ADDR_W),
    .STEP     (STEP),
    .RESET_PC (0)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_stall           (stall),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .o_pc              (pc),
    .o_pc_plus         (pc_plus),
    .o_pc_valid        (pc_valid),
    .o_pending         (pending),
    .o_redirect_ack    (redirect_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_pc;
  bit m_boot;
  bit m_ack;
  int m_pend_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc   = 0;
    m_boot = 1'b1;
    m_ack  = 1'b0;
    m_pend_q.delete();
  endtask

  // One clock edge of the abstract machine.
  task automatic model_step(input bit s, input bit rv, input int tgt);
    m_ack = rv;
    if (m_boot) begin
      if (rv) m_pc = tgt;
      m_boot = 1'b0;
    end else if (s) begin
      if (rv) begin
        m_pend_q.delete();
        m_pend_q.push_back(tgt);
      end
    end else begin
      if (rv)                        m_pc = tgt;
      else if (m_pend_q.size() != 0) m_pc = m_pend_q[0];
      else                           m_pc = (m_pc + STEP) % MOD;
      m_pend_q.delete();
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".pc"},       int'(pc),           m_pc);
    check({where, ".pc_plus"},  int'(pc_plus),      (m_pc + STEP) % MOD);
    check({where, ".pc_valid"}, int'(pc_valid),     m_boot ? 0 : 1);
    check({where, ".pending"},  int'(pending),      (m_pend_q.size() != 0) ? 1 : 0);
    check({where, ".ack"},      int'(redirect_ack), m_ack ? 1 : 0);
  endtask

  // Drive inputs, take one rising edge, then compare 1 time unit later.
  task automatic step(input bit s, input bit rv, input int tgt);
    stall           = s;
    redirect_valid  = rv;
    redirect_target = ADDR_W'(tgt);
    @(posedge clk);
    model_step(s, rv, tgt);
    #1;
    cyc++;
    $display("cyc %0d stall=%0b rv=%0b tgt=%02h -> pc=%02h valid=%0b pend=%0b ack=%0b",
             cyc, s, rv, tgt[7:0], pc, pc_valid, pending, redirect_ack);
    check_outputs("step");
  endtask

  // Reset asserted between edges: outputs must change without a clock,
  // inputs are ignored while held, and sequencing restarts from 0.
  task automatic async_reset();
    #3;
    rst             = 1'b1;
    stall           = 1'($urandom);
    redirect_valid  = 1'b1;
    redirect_target = ADDR_W'($urandom);
    model_reset();
    #1;
    $display("cyc %0d async reset asserted -> pc=%02h valid=%0b pend=%0b ack=%0b",
             cyc, pc, pc_valid, pending, redirect_ack);
    check_outputs("rst_imm");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("rst_rel");
  endtask

  int tgt_r;
  bit s_r, rv_r;

  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("boot");

    // Free run: 0,4,8,12
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);

    // Wrap: redirect to 0xF8, then 0xFC, 0x00
    step(1'b0, 1'b1, 8'hF8);
    step(1'b0, 1'b0, 0);
    check("wrap.pc_plus_fc", int'(pc_plus), 0);
    step(1'b0, 1'b0, 0);

    // Redirect in RUN at 0x10 -> 0x40, 0x44
    step(1'b0, 1'b1, 8'h10);
    step(1'b0, 1'b1, 8'h40);
    step(1'b0, 1'b0, 0);
    check("redir.pc_44", int'(pc), 8'h44);

    // Stall 3 cycles at 0x20 with redirects 0x80 then 0x90
    step(1'b0, 1'b1, 8'h20);
    step(1'b1, 1'b1, 8'h80);
    step(1'b1, 1'b1, 8'h90);
    step(1'b1, 1'b0, 0);
    check("stall.pc_hold", int'(pc), 8'h20);
    step(1'b0, 1'b0, 0);
    check("stall.pc_90", int'(pc), 8'h90);
    step(1'b0, 1'b0, 0);

    // Parked 0x80 superseded by 0xA0 on the release cycle
    step(1'b1, 1'b1, 8'h80);
    step(1'b0, 1'b1, 8'hA0);
    check("supersede.pc_a0", int'(pc), 8'hA0);

    // Reset while a redirect is parked, then BOOT and 0x00, 0x04
    step(1'b1, 1'b1, 8'h80);
    async_reset();
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    check("rst_restart.pc_04", int'(pc), 8'h04);

    // Redirect during BOOT (stall ignored)
    async_reset();
    step(1'b1, 1'b1, 8'h55);
    check("boot_redir.pc", int'(pc), 8'h55);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s_r   = ($urandom_range(0, 99) < 40);
      rv_r  = ($urandom_range(0, 99) < 30);
      tgt_r = int'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 2) async_reset();
      else                           step(s_r, rv_r, tgt_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, program-counter width in bits.
REQ-002 The block SHALL have parameter STEP, default 4, sequential increment, legal range 1 to 2^ADDR_W-1.
REQ-003 The block SHALL have parameter RESET_PC, default 0, PC value loaded by reset.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  high = hold PC this cycle.
REQ-008 redirect_valid  in  1  high = branch/jump request this cycle; no backpressure, always accepted.
REQ-009 redirect_target  in  ADDR_W  target address qualified by redirect_valid.
REQ-010 pc  out  ADDR_W  registered current fetch address.
REQ-011 pc_plus  out  ADDR_W  combinational (pc + STEP) mod 2^ADDR_W.
REQ-012 pc_valid  out  1  registered; high when pc is a valid fetch address.
REQ-013 pending  out  1  registered; high while a redirect is buffered during stall.
REQ-014 redirect_ack  out  1  registered one-cycle pulse in the cycle after each accepted redirect.

Function
REQ-015 The block SHALL implement states BOOT, RUN, HOLD and HOLD_PEND.
REQ-016 BOOT SHALL last exactly one cycle after reset release, then go to RUN; stall SHALL be ignored in BOOT.
REQ-017 In BOOT, redirect_valid=1 SHALL load pc<=redirect_target at the BOOT exit edge; otherwise pc stays RESET_PC.
REQ-018 pc_valid SHALL be 0 in BOOT and 1 in RUN, HOLD and HOLD_PEND.
REQ-019 RUN, stall=0, redirect_valid=0: pc<=pc_plus; state stays RUN.
REQ-020 RUN, stall=0, redirect_valid=1: pc<=redirect_target; no increment that cycle.
REQ-021 RUN or HOLD, stall=1, redirect_valid=0: pc holds; next state HOLD.
REQ-022 RUN, HOLD or HOLD_PEND, stall=1, redirect_valid=1: pc holds; target written to the one-entry pending buffer, newest overwriting older; next state HOLD_PEND.
REQ-023 HOLD, stall=0: behave as RUN with the same inputs (REQ-019/020); next state RUN.
REQ-024 HOLD_PEND, stall=0, redirect_valid=0: pc<=buffered target; buffer cleared; next state RUN.
REQ-025 HOLD_PEND, stall=0, redirect_valid=1: pc<=redirect_target (new request wins); buffer cleared; next state RUN.
REQ-026 pending SHALL be 1 exactly when state is HOLD_PEND.
REQ-027 Increment SHALL wrap modulo 2^ADDR_W with no flag or error (e.g. pc=2^ADDR_W-STEP -> 0).
REQ-028 redirect_ack SHALL pulse for every cycle with redirect_valid=1 in any non-reset state, including overwritten and superseded requests.
REQ-029 pc_plus SHALL be the ADDR_W-bit truncated sum, valid in all states including BOOT.

Reset
REQ-030 rst=1 SHALL immediately, without clk, force pc=RESET_PC, pc_valid=0, pending=0, redirect_ack=0, buffer cleared, state BOOT.
REQ-031 Reset asserted mid-stall or with a pending redirect SHALL discard the buffered target; after release, sequencing restarts from RESET_PC.
REQ-032 While rst=1, all inputs SHALL be ignored.

Verification (ADDR_W=8, STEP=4, RESET_PC=0)
REQ-033 Release rst, stall=0, no redirects -> cycle 0 pc=0 pc_valid=0; then pc=0,4,8,12 with pc_valid=1.
REQ-034 Free-run from pc=0xF8 -> pc=0xFC then 0x00; pc_plus=0x00 when pc=0xFC.
REQ-035 At pc=0x10 RUN, redirect_valid=1 target=0x40 -> next pc=0x40, then 0x44; redirect_ack=1 for one cycle.
REQ-036 pc=0x20, stall=1 for 3 cycles, redirect 0x80 in stall cycle 1 and 0x90 in cycle 2 -> pc holds 0x20, pending=1 from cycle 2; on stall release pc=0x90, pending=0, then 0x94; two ack pulses.
REQ-037 HOLD_PEND with buffered 0x80, stall drops together with redirect 0xA0 -> next pc=0xA0, pending=0.
REQ-038 HOLD_PEND with buffered 0x80, assert rst between clock edges -> outputs reset immediately; after release pc=0x00, pending=0, BOOT cycle then 0x00, 0x04.
